// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with single-outstanding-miss line refill.
// Hits return the word combinationally; misses stall until the line returns.
module icache_fetch #(
    parameter int LINES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic [31:0]  pc_i,
    input  logic         inv_i,
    output logic [31:0]  instruction_o,
    output logic         imembubble_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic [31:0]  mem_addr_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 27 - IDX_W;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MISS_REQ = 2'd1;
    localparam logic [1:0] S_REFILL   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [26:0]      miss_line_q, miss_line_d;
    logic             mem_req_q, mem_req_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [255:0]     data_q [LINES];

    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [2:0]       pc_off;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic [255:0]     rd_line;
    logic             idle_eff;
    logic             hit;
    logic             fill_en;
    logic             unused_pc;

    assign pc_idx    = pc_i[5 +: IDX_W];
    assign pc_tag    = pc_i[31 -: TAG_W];
    assign pc_off    = pc_i[4:2];
    assign miss_idx  = miss_line_q[IDX_W-1:0];
    assign miss_tag  = miss_line_q[26 -: TAG_W];
    assign unused_pc = ^pc_i[1:0];

    // Reset forces the lookup to behave as an idle, fully invalid cache.
    assign idle_eff = rst_i || (state_q == S_IDLE);
    assign rd_line  = data_q[pc_idx];
    assign hit      = !rst_i && (state_q == S_IDLE) && req_i
                   && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign fill_en  = (state_q == S_MISS_REQ) && mem_ack_i;

    assign instruction_o = hit ? rd_line[{pc_off, 5'b0} +: 32] : 32'h0;
    assign imembubble_o  = !hit;
    assign stall_o       = (idle_eff && req_i && !hit) || !idle_eff;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = {miss_line_q, 5'b0};

    always_comb begin
        state_d     = state_q;
        miss_line_d = miss_line_q;
        mem_req_d   = mem_req_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i && !hit) begin
                    miss_line_d = pc_i[31:5];
                    mem_req_d   = 1'b1;
                    state_d     = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = S_REFILL;
                end
            end
            S_REFILL: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Invalidate first, so a coincident refill leaves its own line valid.
    always_comb begin
        valid_d = valid_q;
        if (inv_i) begin
            valid_d = '0;
        end
        if (fill_en) begin
            valid_d[miss_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            miss_line_q <= '0;
            mem_req_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
            mem_req_q   <= mem_req_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: the driver queues expected outputs per
// cycle and an independent negedge monitor pops and compares them.
module tb_icache_fetch;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic [31:0]  pc_i;
    logic         inv_i;
    logic [31:0]  instruction_o;
    logic         imembubble_o;
    logic         stall_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    icache_fetch #(.LINES(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .pc_i(pc_i),
        .inv_i(inv_i),
        .instruction_o(instruction_o),
        .imembubble_o(imembubble_o),
        .stall_o(stall_o),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       nm;
        bit          cf;
        logic [31:0] ins;
        logic        bub;
        logic        stl;
        bit          cm;
        logic        mreq;
        bit          ca;
        logic [31:0] maddr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: compares whatever the driver queued for the current cycle.
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.cf) begin
                check({e.nm, ".instr"}, instruction_o, e.ins);
                check({e.nm, ".bubble"}, {31'b0, imembubble_o}, {31'b0, e.bub});
                check({e.nm, ".stall"}, {31'b0, stall_o}, {31'b0, e.stl});
            end
            if (e.cm) begin
                check({e.nm, ".mem_req"}, {31'b0, mem_req_o}, {31'b0, e.mreq});
            end
            if (e.ca) begin
                check({e.nm, ".mem_addr"}, mem_addr_o, e.maddr);
            end
        end
    end

    task automatic step(string nm, bit rst, bit req, logic [31:0] pc,
                        bit inv, bit ack, logic [255:0] line,
                        bit cf, logic [31:0] ins, bit bub, bit stl,
                        bit cm, bit mreq, bit ca, logic [31:0] maddr);
        exp_t e;
        rst_i      = rst;
        req_i      = req;
        pc_i       = pc;
        inv_i      = inv;
        mem_ack_i  = ack;
        mem_data_i = line;
        e = '{nm, cf, ins, bub, stl, cm, mreq, ca, maddr};
        q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic hit(string nm, logic [31:0] pc, logic [31:0] word);
        step(nm, 0, 1, pc, 0, 0, '0, 1, word, 0, 0, 1, 0, 0, 0);
    endtask

    // Miss detect, wait cycles, ack cycle, refill cycle (stray ack ignored).
    task automatic miss_fill(string nm, logic [31:0] pc, logic [31:0] pc_wait,
                             logic [255:0] line, int waits,
                             bit inv_ack, bit inv_wait);
        logic [31:0] la;
        la = {pc[31:5], 5'b0};
        step({nm, ".miss"}, 0, 1, pc, 0, 0, '0, 1, 0, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < waits; i++) begin
            step({nm, ".wait"}, 0, 1, pc_wait, inv_wait && (i == 0), 0, '0,
                 1, 0, 1, 1, 1, 1, 1, la);
        end
        step({nm, ".ack"}, 0, 1, pc_wait, inv_ack, 1, line,
             1, 0, 1, 1, 1, 1, 1, la);
        step({nm, ".refill"}, 0, 1, pc_wait, 0, 1, ~line,
             1, 0, 1, 1, 1, 0, 1, la);
    endtask

    function automatic logic [255:0] mk(logic [31:0] s);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[32*w +: 32] = s + w * 32'h0101_0101;
        end
        return l;
    endfunction

    logic [255:0] la_line, lb_line, lc_line, ld_line;

    initial begin
        rst_i      = 1'b1;
        req_i      = 1'b0;
        pc_i       = '0;
        inv_i      = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        la_line = mk(32'hA000_0000);
        la_line[63:32] = 32'hDEAD_BEEF;
        lb_line = mk(32'hB000_0010);
        lc_line = mk(32'hC000_0020);
        ld_line = mk(32'hD000_0030);
        @(posedge clk_i);
        #1;

        step("rst0", 1, 0, 0, 0, 0, '0, 1, 0, 1, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, '0, 1, 0, 1, 0, 1, 0, 1, 0);

        miss_fill("cold", 32'h104, 32'h104, la_line, 3, 0, 0);
        hit("cold_hit", 32'h104, 32'hDEAD_BEEF);
        hit("same_line", 32'h11C, la_line[255:224]);
        step("idle_noreq", 0, 0, 32'h11C, 0, 0, '0,
             1, 0, 1, 0, 1, 0, 0, 0);

        miss_fill("conflict", 32'h300, 32'h300, lb_line, 1, 0, 0);
        hit("conflict_hit0", 32'h300, lb_line[31:0]);
        hit("conflict_hit2", 32'h308, lb_line[95:64]);

        miss_fill("remiss", 32'h104, 32'h2000, la_line, 2, 0, 0);
        hit("remiss_hit", 32'h104, 32'hDEAD_BEEF);
        miss_fill("pc2000", 32'h2000, 32'h2000, lc_line, 0, 0, 0);
        hit("pc2000_hit", 32'h2004, lc_line[63:32]);
        hit("line8_kept", 32'h110, la_line[159:128]);

        step("inv", 0, 0, 32'h104, 1, 0, '0, 1, 0, 1, 0, 1, 0, 0, 0);
        miss_fill("inv_miss", 32'h104, 32'h104, la_line, 1, 1, 1);
        hit("inv_ack_hit", 32'h104, 32'hDEAD_BEEF);
        miss_fill("inv_other", 32'h2000, 32'h2000, lc_line, 0, 0, 0);
        hit("inv_other_hit", 32'h2000, lc_line[31:0]);

        step("rst_miss", 0, 1, 32'h300, 0, 0, '0,
             1, 0, 1, 1, 1, 0, 0, 0);
        step("rst_mreq", 1, 1, 32'h300, 0, 0, '0,
             1, 0, 1, 1, 1, 1, 1, 32'h300);
        step("post_rst_ack", 0, 0, 32'h300, 0, 1, ld_line,
             1, 0, 1, 0, 1, 0, 1, 0);
        miss_fill("orig_remiss", 32'h300, 32'h300, lb_line, 0, 0, 0);
        hit("orig_hit", 32'h31C, lb_line[255:224]);
        step("end_idle", 0, 0, 0, 0, 0, '0, 1, 0, 1, 0, 1, 0, 0, 0);

        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameter: LINES, default 16, number of direct-mapped lines; power of two, 2..256.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high; sampled on rising edge of clk_i.
REQ-004 req_i  input  1  fetch request valid for pc_i this cycle.
REQ-005 pc_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 inv_i  input  1  invalidate entire cache.
REQ-007 instruction_o  output  32  fetched instruction word, combinational.
REQ-008 imembubble_o  output  1  1 = instruction_o is bogus (miss or no request), combinational.
REQ-009 stall_o  output  1  request pipeline stall while miss is outstanding, combinational.
REQ-010 mem_req_o  output  1  line refill request to memory, registered.
REQ-011 mem_addr_o  output  32  line-aligned refill address ({tag,index,5'b0}), registered.
REQ-012 mem_ack_i  input  1  memory returns line this cycle.
REQ-013 mem_data_i  input  256  refill line; word w at bits [32w+31:32w].

Function
REQ-014 Line = 32 bytes (8 words); offset = pc[4:2], index = pc[4+log2(LINES):5], tag = remaining upper bits.
REQ-015 Per line storage: valid bit, tag, 256-bit data.
REQ-016 States: IDLE, MISS_REQ, REFILL.
REQ-017 Hit = state IDLE, req_i=1, valid[index]=1, tag[index]=tag(pc_i).
REQ-018 On hit: instruction_o = word[offset] of line, imembubble_o=0, stall_o=0, zero-cycle latency.
REQ-019 In all non-hit cases: instruction_o=0, imembubble_o=1.
REQ-020 stall_o = 1 when (IDLE and req_i=1 and not hit) or state != IDLE.
REQ-021 IDLE, req_i=1, miss: latch line address of pc_i into miss register; next state MISS_REQ.
REQ-022 IDLE, req_i=0: no state change, no memory activity, stall_o=0.
REQ-023 MISS_REQ: mem_req_o=1, mem_addr_o = latched line address, both held stable until mem_ack_i=1.
REQ-024 MISS_REQ with mem_ack_i=1: write mem_data_i, tag and valid=1 into latched index on that edge; mem_req_o=0 next cycle; next state REFILL.
REQ-025 mem_ack_i outside MISS_REQ SHALL be ignored.
REQ-026 REFILL: one cycle, stall_o=1, imembubble_o=1; next state IDLE unconditionally.
REQ-027 Miss penalty: first hit on the refilled address occurs in the second cycle after the mem_ack_i cycle (ack cycle N, REFILL N+1, hit N+2).
REQ-028 Refill targets the latched address; changes on pc_i while stall_o=1 SHALL not alter the refill.
REQ-029 inv_i=1 clears all valid bits on that edge, in any state; state and an outstanding mem_req_o are unaffected.
REQ-030 inv_i=1 in the same cycle as a refill write: invalidate applies to all lines, then the refill line is written valid (refill wins for its index).
REQ-031 A refill that replaces a valid line with a different tag overwrites it (no write-back; instruction cache is read-only).

Reset
REQ-032 rst_i=1: state=IDLE, all valid bits=0, mem_req_o=0, mem_addr_o=0, miss register=0; tag/data contents need not be cleared.
REQ-033 Reset asserted mid-miss (MISS_REQ or REFILL) SHALL abandon the refill; mem_req_o=0 in the cycle after the reset edge; a mem_ack_i arriving afterwards is ignored.
REQ-034 While rst_i=1, outputs follow REQ-019/020 with state IDLE and all lines invalid.

Verification
REQ-035 Cold miss: reset, req_i=1, pc_i=0x0000_0104 -> imembubble_o=1, stall_o=1; next cycle mem_req_o=1, mem_addr_o=0x0000_0100; ack 3 cycles later with word1=0xDEADBEEF -> two cycles after ack, instruction_o=0xDEADBEEF, imembubble_o=0, stall_o=0.
REQ-036 Same-line hit: after REQ-035, pc_i=0x0000_011C -> instruction_o=word7 of that line same cycle, no mem_req_o.
REQ-037 Conflict miss (LINES=16): pc_i=0x0000_0300 (same index 8, different tag) -> miss, mem_addr_o=0x0000_0300; afterwards pc_i=0x0000_0104 misses again.
REQ-038 pc_i changed to 0x0000_2000 during MISS_REQ -> mem_addr_o stays 0x0000_0100 until ack; 0x2000 misses after return to IDLE.
REQ-039 inv_i=1 for one cycle in IDLE after fills -> previously hitting pc_i now misses; inv_i coincident with mem_ack_i -> refilled line hits, all others miss.
REQ-040 rst_i=1 during MISS_REQ, then mem_ack_i=1 -> mem_req_o=0 after reset edge, no line written, original pc_i misses again.
